// File: rtl/text_console_ctrl_pkg.sv
// Shared definitions for the text console write sequencer: controller states,
// ASCII control codes and the {row,col} buffer address packing.
package text_console_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WRITE,
        ST_SCROLL,
        ST_CLEAR_ROW
    } state_t;

    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] BS    = 8'h08;

    // Buffer address: row in the upper 5 bits, column in the lower 7 bits.
    function automatic logic [11:0] pack_addr(input logic [4:0] row, input logic [6:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/text_console_ctrl_if.sv
// Character input handshake plus the text buffer read/write port.
// The controller uses the master view; the byte source and buffer use slave.
interface text_console_ctrl_if;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        mem_we;
    logic [11:0] mem_waddr;
    logic [7:0]  mem_wdata;
    logic [11:0] mem_raddr;
    logic [7:0]  mem_rdata;

    modport master (
        input  char_valid, char_data, mem_rdata,
        output char_ready, mem_we, mem_waddr, mem_wdata, mem_raddr
    );

    modport slave (
        output char_valid, char_data, mem_rdata,
        input  char_ready, mem_we, mem_waddr, mem_wdata, mem_raddr
    );
endinterface

// File: rtl/text_console_ctrl_cell_walker.sv
// Row/column sweep counter. After start it visits every column of each row
// from start_row to end_row (inclusive), one cell per cycle, then goes idle
// holding the last cell. A new start on the last cell chains sweeps with no gap.
module console_cell_walker #(
    parameter int COLS        = 70,
    parameter int ROWS        = 30,
    parameter bit INIT_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] start_row,
    input  logic [4:0] end_row,
    output logic [4:0] row,
    output logic [6:0] col,
    output logic       active,
    output logic       last
);

    localparam logic [6:0] COL_MAX = 7'(COLS - 1);
    localparam logic [4:0] ROW_MAX = 5'(ROWS - 1);

    logic [4:0] end_q;

    // Sweep position; on reset optionally begins a full-screen sweep at {0,0}.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row    <= '0;
            col    <= '0;
            end_q  <= ROW_MAX;
            active <= INIT_ACTIVE;
        end else if (start) begin
            row    <= start_row;
            col    <= '0;
            end_q  <= end_row;
            active <= 1'b1;
        end else if (active) begin
            if (col == COL_MAX) begin
                if (row == end_q) begin
                    active <= 1'b0;
                end else begin
                    col <= '0;
                    row <= row + 5'd1;
                end
            end else begin
                col <= col + 7'd1;
            end
        end
    end

    assign last = active && (col == COL_MAX) && (row == end_q);

endmodule

// File: rtl/text_console_ctrl.sv
// Text console write sequencer: consumes ASCII bytes, keeps the cursor,
// writes characters into the text buffer and scrolls it up when the cursor
// runs past the last row. Buffer writes are issued one cycle after the
// decision that produces them.
module text_console_ctrl
    import text_console_pkg::*;
#(
    parameter int COLS           = 70,
    parameter int ROWS           = 30,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                rst,
    text_console_ctrl_if.master bus,
    output logic [4:0]          cursor_row,
    output logic [6:0]          cursor_col,
    output logic                busy
);

    localparam logic [6:0] COL_MAX     = 7'(COLS - 1);
    localparam logic [4:0] ROW_MAX     = 5'(ROWS - 1);
    localparam state_t     RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_IDLE;

    state_t      state, state_nxt;
    logic [4:0]  row_nxt;
    logic [6:0]  col_nxt;
    logic        we_nxt, from_rd_nxt;
    logic [11:0] waddr_nxt;
    logic [7:0]  wdata_nxt;
    logic        we_q, from_rd_q;
    logic [11:0] waddr_q;
    logic [7:0]  wdata_q;

    logic        walk_start;
    logic [4:0]  walk_srow, walk_erow;
    logic [4:0]  w_row;
    logic [6:0]  w_col;
    logic        w_active, w_last;

    logic [7:0]  ch;
    logic        is_print;

    assign ch       = bus.char_data;
    assign is_print = (ch >= 8'h20) && (ch <= 8'h7E);

    console_cell_walker #(
        .COLS        (COLS),
        .ROWS        (ROWS),
        .INIT_ACTIVE (CLEAR_ON_RESET != 0)
    ) u_walker (
        .clk       (clk),
        .rst       (rst),
        .start     (walk_start),
        .start_row (walk_srow),
        .end_row   (walk_erow),
        .row       (w_row),
        .col       (w_col),
        .active    (w_active),
        .last      (w_last)
    );

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RESET_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, cursor movement, sweep control and the write to issue next cycle.
    always_comb begin
        state_nxt   = state;
        row_nxt     = cursor_row;
        col_nxt     = cursor_col;
        we_nxt      = 1'b0;
        from_rd_nxt = 1'b0;
        waddr_nxt   = waddr_q;
        wdata_nxt   = wdata_q;
        walk_start  = 1'b0;
        walk_srow   = ROW_MAX;
        walk_erow   = ROW_MAX;

        case (state)
            ST_INIT: begin
                if (w_active) begin
                    we_nxt    = 1'b1;
                    waddr_nxt = pack_addr(w_row, w_col);
                    wdata_nxt = SPACE;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (bus.char_valid) begin
                    if (is_print || ch == LF || ch == CR) begin
                        if (is_print) begin
                            we_nxt    = 1'b1;
                            waddr_nxt = pack_addr(cursor_row, cursor_col);
                            wdata_nxt = ch;
                        end
                        state_nxt = ST_WRITE;
                        if (is_print && cursor_col != COL_MAX) begin
                            col_nxt = cursor_col + 7'd1;
                        end else begin
                            col_nxt = '0;
                            if (cursor_row == ROW_MAX) begin
                                // Cursor ran off the bottom: copy rows 1..ROWS-1 up by one.
                                state_nxt  = ST_SCROLL;
                                walk_start = 1'b1;
                                walk_srow  = 5'd1;
                                walk_erow  = ROW_MAX;
                            end else begin
                                row_nxt = cursor_row + 5'd1;
                            end
                        end
                    end else if (ch == BS) begin
                        if (cursor_col != 7'd0) begin
                            col_nxt   = cursor_col - 7'd1;
                            we_nxt    = 1'b1;
                            waddr_nxt = pack_addr(cursor_row, cursor_col - 7'd1);
                            wdata_nxt = SPACE;
                            state_nxt = ST_WRITE;
                        end else if (cursor_row != 5'd0) begin
                            row_nxt   = cursor_row - 5'd1;
                            col_nxt   = COL_MAX;
                            we_nxt    = 1'b1;
                            waddr_nxt = pack_addr(cursor_row - 5'd1, COL_MAX);
                            wdata_nxt = SPACE;
                            state_nxt = ST_WRITE;
                        end
                    end
                end
            end

            ST_WRITE: begin
                state_nxt = ST_IDLE;
            end

            ST_SCROLL: begin
                // The walker drives the read row; the data lands one row higher a cycle later.
                if (w_active) begin
                    we_nxt      = 1'b1;
                    from_rd_nxt = 1'b1;
                    waddr_nxt   = pack_addr(w_row - 5'd1, w_col);
                    if (w_last) begin
                        state_nxt  = ST_CLEAR_ROW;
                        walk_start = 1'b1;
                        walk_srow  = ROW_MAX;
                        walk_erow  = ROW_MAX;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end

            ST_CLEAR_ROW: begin
                if (w_active) begin
                    we_nxt    = 1'b1;
                    waddr_nxt = pack_addr(w_row, w_col);
                    wdata_nxt = SPACE;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered write port; reset kills any write in flight immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q      <= 1'b0;
            from_rd_q <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            we_q      <= we_nxt;
            from_rd_q <= from_rd_nxt;
            waddr_q   <= waddr_nxt;
            wdata_q   <= wdata_nxt;
        end
    end

    // Cursor position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cursor_row <= '0;
            cursor_col <= '0;
        end else begin
            cursor_row <= row_nxt;
            cursor_col <= col_nxt;
        end
    end

    // During a scroll copy the write data is the buffer's registered read output.
    assign bus.mem_we     = we_q;
    assign bus.mem_waddr  = waddr_q;
    assign bus.mem_wdata  = from_rd_q ? bus.mem_rdata : wdata_q;
    assign bus.mem_raddr  = pack_addr(w_row, w_col);
    assign bus.char_ready = (state == ST_IDLE) && !rst;
    assign busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_text_console_ctrl.sv
// Bench for text_console_ctrl: a byte-addressed buffer model behind the
// memory port and a reference console kept as a 2-D character grid with a
// linear cursor position.
module tb_text_console_ctrl;

    localparam int COLS     = 70;
    localparam int ROWS     = 30;
    localparam int NCELLS   = ROWS * COLS;
    localparam int SCROLL_T = (ROWS - 1) * COLS + 1 + COLS;
    localparam logic [7:0] C_SP = 8'h20;
    localparam logic [7:0] C_LF = 8'h0A;
    localparam logic [7:0] C_CR = 8'h0D;
    localparam logic [7:0] C_BS = 8'h08;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] cursor_row;
    logic [6:0] cursor_col;
    logic       busy;

    text_console_ctrl_if bus ();

    text_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .CLEAR_ON_RESET(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Text buffer with a one-cycle registered read.
    logic [7:0] mem [4096];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_waddr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_raddr];
    end

    int total = 0;
    int bad   = 0;
    int addr_viol = 0;

    // Watch for any access to a column or row outside the visible grid.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_we && (int'(bus.mem_waddr[6:0]) >= COLS || int'(bus.mem_waddr[11:7]) >= ROWS))
                addr_viol++;
            if (int'(bus.mem_raddr[6:0]) >= COLS || int'(bus.mem_raddr[11:7]) >= ROWS)
                addr_viol++;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference console.
    logic [7:0] scr [ROWS][COLS];
    int mrow = 0;
    int mcol = 0;

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) scr[r][c] = C_SP;
        mrow = 0;
        mcol = 0;
    endtask

    task automatic model_step(input logic [7:0] b, output bit e_we, output int e_addr,
                              output int e_data, output int e_lat);
        int pos;
        pos = mrow * COLS + mcol;
        e_we = 0; e_addr = 0; e_data = 0; e_lat = 0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            scr[mrow][mcol] = b;
            e_we = 1; e_addr = mrow * 128 + mcol; e_data = int'(b); e_lat = 1;
            pos++;
        end else if (b == C_LF || b == C_CR) begin
            pos = (mrow + 1) * COLS;
            e_lat = 1;
        end else if (b == C_BS && pos > 0) begin
            pos--;
            scr[pos / COLS][pos % COLS] = C_SP;
            e_we = 1; e_addr = (pos / COLS) * 128 + pos % COLS; e_data = int'(C_SP); e_lat = 1;
        end
        if (pos >= NCELLS) begin
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++) scr[r][c] = scr[r + 1][c];
            for (int c = 0; c < COLS; c++) scr[ROWS - 1][c] = C_SP;
            pos = (ROWS - 1) * COLS;
            e_lat = SCROLL_T;
        end
        mrow = pos / COLS;
        mcol = pos % COLS;
    endtask

    task automatic check_screen(input string tag);
        int mism;
        mism = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (mem[r * 128 + c] !== scr[r][c]) mism++;
        check(tag, mism, 0);
    endtask

    // Observations from the two cycles following a consumed byte.
    logic        obs_we    [2];
    logic [11:0] obs_waddr [2];
    logic [7:0]  obs_wdata [2];
    logic [11:0] obs_raddr [2];
    int          obs_row, obs_col, obs_lat;

    task automatic send(input logic [7:0] b);
        bit ok;
        bit e_we;
        int e_addr, e_data, e_lat;
        ok = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (bus.char_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            check("ready_wait", 0, 1);
            return;
        end
        bus.char_valid = 1'b1;
        bus.char_data  = b;
        @(posedge clk);
        #1;
        bus.char_valid = 1'b0;
        model_step(b, e_we, e_addr, e_data, e_lat);
        for (int i = 0; i < 2; i++) begin
            obs_we[i] = 0; obs_waddr[i] = 0; obs_wdata[i] = 0; obs_raddr[i] = 0;
        end
        obs_lat = -1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (i < 2) begin
                obs_we[i]    = bus.mem_we;
                obs_waddr[i] = bus.mem_waddr;
                obs_wdata[i] = bus.mem_wdata;
                obs_raddr[i] = bus.mem_raddr;
            end
            if (i == 0) begin
                obs_row = int'(cursor_row);
                obs_col = int'(cursor_col);
            end
            if (bus.char_ready) begin obs_lat = i; break; end
        end
        check("cursor_row", obs_row, mrow);
        check("cursor_col", obs_col, mcol);
        check("write_strobe", int'(obs_we[0]), int'(e_we));
        if (e_we) begin
            check("write_addr", int'(obs_waddr[0]), e_addr);
            check("write_data", int'(obs_wdata[0]), e_data);
        end
        check("busy_cycles", obs_lat, e_lat);
    endtask

    initial begin
        int n_wr, n_cov, last_we, rdy_at, stray;
        bit ok;
        bit cov [ROWS][COLS];
        logic [7:0] b, first_copy;
        int sel;

        bus.char_valid = 1'b0;
        bus.char_data  = 8'h00;

        // Reset values while held in reset.
        repeat (3) @(negedge clk);
        check("rst_we", int'(bus.mem_we), 0);
        check("rst_waddr", int'(bus.mem_waddr), 0);
        check("rst_raddr", int'(bus.mem_raddr), 0);
        check("rst_wdata", int'(bus.mem_wdata), 0);
        check("rst_ready", int'(bus.char_ready), 0);
        check("rst_cursor", int'({cursor_row, cursor_col}), 0);
        rst = 1'b0;

        // Initial clear of the whole visible buffer.
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) cov[r][c] = 0;
        n_wr = 0; n_cov = 0; last_we = -10; rdy_at = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.mem_we) begin
                n_wr++;
                last_we = i;
                if (bus.mem_wdata == C_SP && int'(bus.mem_waddr[6:0]) < COLS &&
                    int'(bus.mem_waddr[11:7]) < ROWS && !cov[bus.mem_waddr[11:7]][bus.mem_waddr[6:0]]) begin
                    cov[bus.mem_waddr[11:7]][bus.mem_waddr[6:0]] = 1;
                    n_cov++;
                end
            end
            if (bus.char_ready) begin rdy_at = i; break; end
        end
        check("init_writes", n_wr, NCELLS);
        check("init_cells_covered", n_cov, NCELLS);
        check("init_ready_after_last_write", rdy_at, last_we + 1);
        check("init_cursor", int'({cursor_row, cursor_col}), 0);
        model_clear();
        check_screen("init_screen");

        // Backspace at the origin does nothing.
        send(C_BS);

        // Single printable at the origin.
        send(8'h41);
        check("A_addr", int'(obs_waddr[0]), 0);
        check("A_data", int'(obs_wdata[0]), 8'h41);

        // Back to origin, then a full row of printables wraps to the next row.
        send(C_BS);
        for (int i = 0; i < COLS; i++) send(8'($urandom_range(32, 126)));
        check("row_fill_last_addr", int'(obs_waddr[0]), 69);
        check("row_fill_cursor", obs_row * 128 + obs_col, 1 * 128 + 0);

        // Backspace from column 0 moves to the end of the previous row.
        send(C_LF);
        send(C_CR);
        send(C_BS);
        check("bs_wrap_addr", int'(obs_waddr[0]), 2 * 128 + 69);
        check("bs_wrap_cursor", obs_row * 128 + obs_col, 2 * 128 + 69);
        check_screen("screen_after_bs");

        // Newline on the last row scrolls the screen.
        while (mrow != ROWS - 1) send(C_LF);
        for (int i = 0; i < 5; i++) send(8'($urandom_range(33, 126)));
        first_copy = scr[1][0];
        send(C_LF);
        check("scroll_first_raddr", int'(obs_raddr[0]), 1 * 128 + 0);
        check("scroll_first_we", int'(obs_we[1]), 1);
        check("scroll_first_waddr", int'(obs_waddr[1]), 0);
        check("scroll_first_wdata", int'(obs_wdata[1]), int'(first_copy));
        check_screen("screen_after_scroll");

        // Random byte stream.
        for (int n = 0; n < 200; n++) begin
            sel = $urandom_range(0, 99);
            if (sel < 70)      b = 8'($urandom_range(32, 126));
            else if (sel < 78) b = C_LF;
            else if (sel < 82) b = C_CR;
            else if (sel < 92) b = C_BS;
            else if (sel < 96) b = 8'($urandom_range(0, 7));
            else               b = 8'($urandom_range(127, 255));
            send(b);
        end
        check_screen("screen_after_random");

        // Reset in the middle of a scroll.
        while (mrow != ROWS - 1) send(C_LF);
        ok = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (bus.char_ready) begin ok = 1; break; end
        end
        check("pre_scroll_ready", int'(ok), 1);
        bus.char_valid = 1'b1;
        bus.char_data  = C_LF;
        @(posedge clk);
        #1;
        bus.char_valid = 1'b0;
        repeat (500) @(negedge clk);
        check("mid_scroll_we", int'(bus.mem_we), 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_we_drop", int'(bus.mem_we), 0);
        check("rst_mid_ready", int'(bus.char_ready), 0);
        check("rst_mid_cursor", int'({cursor_row, cursor_col}), 0);
        bus.char_valid = 1'b1;
        bus.char_data  = 8'h5A;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_wr = 0; stray = 0; ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.mem_we) begin
                n_wr++;
                if (bus.mem_wdata != C_SP) stray++;
            end
            if (bus.char_ready) begin ok = 1; break; end
        end
        check("reinit_ready", int'(ok), 1);
        check("reinit_writes", n_wr, NCELLS);
        check("reinit_no_early_consume", stray, 0);
        @(posedge clk);
        #1;
        bus.char_valid = 1'b0;
        @(negedge clk);
        check("held_byte_we", int'(bus.mem_we), 1);
        check("held_byte_addr", int'(bus.mem_waddr), 0);
        check("held_byte_data", int'(bus.mem_wdata), 8'h5A);
        check("held_byte_cursor", int'(cursor_row) * 128 + int'(cursor_col), 1);
        @(negedge clk);
        model_clear();
        begin
            bit e_we;
            int e_addr, e_data, e_lat;
            model_step(8'h5A, e_we, e_addr, e_data, e_lat);
        end
        check_screen("screen_after_reinit");

        check("addr_range", addr_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
